// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM scheduler: per-line prefetch into a ping-pong line buffer for VGA scanout,
// with drawing-engine writes granted in the leftover slots. Optional build macro: VGA_FB_UNDERRUN_EN.
module vga_fb_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_AW    = 19,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic [9:0]       line_y,
    input  logic [9:0]       pix_x,
    input  logic             pix_active,
    output logic [PIX_W-1:0] pix_rgb,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic             ram_en,
    output logic             ram_we,
    output logic [FB_AW-1:0] ram_addr,
    output logic [PIX_W-1:0] ram_wdata,
    input  logic [PIX_W-1:0] ram_rdata,
    output logic             fetch_busy,
    output logic             underrun
);

    localparam int CNT_W  = $clog2(H_ACTIVE);
    localparam int PROD_W = FB_AW + 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [9:0]       H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [FB_AW-1:0]   base, base_n;
    logic               disp_sel, disp_sel_n;
    logic               fill_issue;
    logic               fill_pend;
    logic [CNT_W-1:0]   fill_idx;
    logic [PROD_W-1:0]  line_base;
    logic [PIX_W-1:0]   line_buf [2][H_ACTIVE];

    assign line_base = PROD_W'(line_y) * PROD_W'(H_ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            disp_sel  <= 1'b0;
            fill_pend <= 1'b0;
            fill_idx  <= '0;
            pix_rgb   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            base      <= base_n;
            disp_sel  <= disp_sel_n;
            fill_pend <= fill_issue;
            fill_idx  <= cnt;
            pix_rgb   <= (pix_active && pix_x < H_LIM) ? line_buf[disp_sel][pix_x] : '0;
        end
    end

    // Read data lands one cycle after issue; a line_start on that edge aborts the fill.
    always_ff @(posedge clk) begin
        if (fill_pend && !line_start)
            line_buf[~disp_sel][fill_idx] <= ram_rdata;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        base_n     = base;
        disp_sel_n = disp_sel;
        wr_ready   = 1'b0;
        fetch_busy = 1'b0;
        fill_issue = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        case (state)
            IDLE: begin
                wr_ready = 1'b1;
            end
            FETCH: begin
                fetch_busy = 1'b1;
                // A read issued in an aborting cycle would be discarded, so it is not issued.
                if (!line_start) begin
                    ram_en     = 1'b1;
                    ram_addr   = base + FB_AW'(cnt);
                    fill_issue = 1'b1;
                    if (cnt == CNT_LAST)
                        state_n = DRAIN;
                    else
                        cnt_n = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                fetch_busy = 1'b1;
                wr_ready   = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (wr_valid && wr_ready) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end

        if (line_start) begin
            disp_sel_n = ~disp_sel;
            cnt_n      = '0;
            if (line_y < V_LIM) begin
                state_n = FETCH;
                base_n  = line_base[FB_AW-1:0];
            end else begin
                state_n = IDLE;
            end
        end
    end

`ifdef VGA_FB_UNDERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun <= 1'b0;
        else if (line_start && state != IDLE)
            underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: line-level reference model checked every cycle plus directed literal checks.
module tb_vga_fb_scheduler;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 19;
    localparam int PW = 12;
`ifdef VGA_FB_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          line_start;
    logic [9:0]    line_y;
    logic [9:0]    pix_x;
    logic          pix_active;
    logic [PW-1:0] pix_rgb;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [PW-1:0] ram_wdata;
    logic [PW-1:0] ram_rdata;
    logic          fetch_busy;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .FB_AW(AW), .PIX_W(PW)) dut (
        .clk(clk), .reset(rst), .line_start(line_start), .line_y(line_y),
        .pix_x(pix_x), .pix_active(pix_active), .pix_rgb(pix_rgb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    // Framebuffer: unwritten words read back as the low 12 bits of their address.
    logic [PW-1:0] wmem [int];

    function automatic logic [PW-1:0] fb_val(input int a);
        return wmem.exists(a) ? wmem[a] : PW'(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) wmem[int'(ram_addr)] = ram_wdata;
            else        ram_rdata <= fb_val(int'(ram_addr));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age = 0 idle, 1..H = read m_age-1, H+1 = drain cycle.
    int            m_age = 0;
    int            m_base = 0;
    bit            m_disp = 1'b0;
    bit            m_ok [2] = '{1'b0, 1'b0};
    int            m_line [2] = '{0, 0};
    logic [PW-1:0] m_pix = '0;
    bit            m_pix_chk = 1'b1;
    bit            m_ur = 1'b0;
    bit            e_read, e_busy, e_rdy;

    always @(negedge clk) begin
        if (rst) begin
            m_age = 0; m_disp = 1'b0; m_ok[0] = 1'b0; m_ok[1] = 1'b0;
            m_pix = '0; m_pix_chk = 1'b1; m_ur = 1'b0;
        end
        e_read = (m_age >= 1 && m_age <= H) && !line_start;
        e_busy = (m_age >= 1 && m_age <= H + 1);
        e_rdy  = !(m_age >= 1 && m_age <= H);
        chk("wr_ready", wr_ready, e_rdy);
        chk("fetch_busy", fetch_busy, e_busy);
        if (e_read) begin
            chk("rd_en", ram_en, 1);
            chk("rd_we", ram_we, 0);
            chk("rd_addr", ram_addr, (m_base + m_age - 1) % (1 << AW));
        end else if (wr_valid && e_rdy) begin
            chk("wr_en", ram_en, 1);
            chk("wr_we", ram_we, 1);
            chk("wr_addr", ram_addr, wr_addr);
            chk("wr_data", ram_wdata, wr_data);
        end else begin
            chk("idle_en", ram_en, 0);
        end
        if (m_pix_chk) chk("pix_rgb", pix_rgb, m_pix);
        chk("underrun", underrun, UR_EN ? m_ur : 1'b0);

        if (!rst) begin
            if (pix_active && pix_x < H) begin
                m_pix_chk = m_ok[m_disp];
                m_pix     = fb_val(m_line[m_disp] * H + int'(pix_x));
            end else begin
                m_pix_chk = 1'b1;
                m_pix     = '0;
            end
            if (line_start) begin
                if (m_age != 0) m_ur = 1'b1;
                m_disp = !m_disp;
                if (line_y < V) begin
                    m_age = 1;
                    m_base = int'(line_y) * H;
                    m_ok[!m_disp] = 1'b0;
                    m_line[!m_disp] = int'(line_y);
                end else begin
                    m_age = 0;
                end
            end else if (m_age == H + 1) begin
                m_ok[!m_disp] = 1'b1;
                m_age = 0;
            end else if (m_age != 0) begin
                m_age++;
            end
        end
    end

    // Activity counters for the directed checks.
    int            n_rd, n_wr, n_busy, n_nrdy;
    logic [AW-1:0] first_rd, last_rd;

    always @(negedge clk) begin
        if (ram_en && !ram_we) begin
            n_rd++;
            if (n_rd == 1) first_rd = ram_addr;
            last_rd = ram_addr;
        end
        if (ram_en && ram_we) n_wr++;
        if (fetch_busy) n_busy++;
        if (!wr_ready) n_nrdy++;
    end

    task automatic clr();
        n_rd = 0; n_wr = 0; n_busy = 0; n_nrdy = 0; first_rd = '0; last_rd = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input int y);
        line_y = 10'(y);
        line_start = 1'b1;
        step(1);
        line_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; line_start = 1'b0; line_y = '0; pix_x = '0; pix_active = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clr();
        step(3);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_pix", pix_rgb, 0);
        chk("rst_en", ram_en, 0);
        chk("rst_ur", underrun, 0);
        chk("rst_rdy", wr_ready, 1);
        rst = 1'b0;
        step(2);

        // Full fetch of line 0
        clr();
        pulse_line(0);
        step(645);
        chk("t1_reads", n_rd, 640);
        chk("t1_first", first_rd, 0);
        chk("t1_last", last_rd, 639);
        chk("t1_busy", n_busy, 641);
        chk("t1_writes", n_wr, 0);

        // Line 5 fetched, displayed after the next swap
        pulse_line(5);
        step(645);
        pulse_line(6);
        pix_x = 10'd3; pix_active = 1'b1;
        step(1);
        chk("t2_pix", pix_rgb, 3203);
        foreach (pix_x[i]) begin end
        pix_x = 10'd0;    step(1);
        pix_x = 10'd639;  step(1);
        pix_x = 10'd640;  step(1);
        chk("t2_pix_oob", pix_rgb, 0);
        pix_x = 10'd1023; step(1);
        pix_active = 1'b0;
        step(645);

        // Writer held across line_start
        wr_addr = 19'd400000; wr_data = 12'hABC; wr_valid = 1'b1;
        clr();
        pulse_line(7);
        step(640);
        chk("t3_writes_fetch", n_wr, 1);
        chk("t3_notready", n_nrdy, 640);
        step(1);
        wr_valid = 1'b0;
        chk("t3_writes_drain", n_wr, 2);
        chk("t3_reads", n_rd, 640);
        step(5);

        // Out-of-range line: swap only
        clr();
        pix_x = 10'd3; pix_active = 1'b1;
        pulse_line(480);
        step(1);
        chk("t4_pix", pix_rgb, 387);
        step(5);
        chk("t4_reads", n_rd, 0);
        chk("t4_notready", n_nrdy, 0);
        chk("t4_busy", n_busy, 0);

        // Abort and restart mid-fetch
        pulse_line(10);
        step(99);
        clr();
        pulse_line(11);
        step(3);
        chk("t5_first", first_rd, 7040);
        chk("t5_underrun", underrun, UR_EN);
        step(645);
        chk("t5_reads", n_rd, 640);
        pulse_line(480);
        step(1);
        chk("t5_pix", pix_rgb, 2947);

        // Reset in the middle of a fetch
        pulse_line(480);
        pulse_line(20);
        step(300);
        chk("t6_addr", ram_addr, 13100);
        chk("t6_pix_pre", pix_rgb, 2947);
        rst = 1'b1;
        #1;
        chk("t6_en", ram_en, 0);
        chk("t6_busy", fetch_busy, 0);
        chk("t6_pix", pix_rgb, 0);
        chk("t6_ur", underrun, 0);
        step(2);
        rst = 1'b0;
        step(1);
        clr();
        pulse_line(1);
        step(645);
        chk("t6_first", first_rd, 640);
        chk("t6_reads", n_rd, 640);
        chk("t6_rbusy", n_busy, 641);
        pix_active = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
